exc_track: RTL and testbench

Parametrised pipelined exception tracker for the five-stage MIPS core. Detects fetch, decode, execute and memory-stage exceptions and carries the earliest one per instruction down the F/D/E/M pipe registers. Commits exceptions and masked hardware interrupts at M, and sequences the NORMAL/HANDLER state around `eret`. It sits beside the hazard unit and feeds CP0 (Cause/EPC) and the pipeline flush network.

---
 rtl/exc_track_if.sv | 24 ++
 rtl/exc_track.sv | 114 +++++++++++
 tb/tb_exc_track.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/exc_track_if.sv
// exc_track_if: core-side stage signals and CP0/flush results of the exception tracker
interface exc_track_if #(parameter int NIRQ = 6);
  logic            stall;
  logic [31:0]     pc_f;
  logic            ri_d;
  logic            bd_d;
  logic            eret_d;
  logic [2:0]      memop_e;
  logic            ov_e;
  logic [31:0]     addr_m;
  logic [NIRQ-1:0] irq;
  logic [NIRQ-1:0] im;
  logic            ie;
  logic            exc_flush;
  logic [4:0]      exc_code;
  logic [31:0]     exc_epc;
  logic            exc_bd;
  logic            in_handler;
  logic [NIRQ-1:0] pend;
  modport master(output stall, pc_f, ri_d, bd_d, eret_d, memop_e, ov_e, addr_m, irq, im, ie,
                 input exc_flush, exc_code, exc_epc, exc_bd, in_handler, pend);
  modport slave(input stall, pc_f, ri_d, bd_d, eret_d, memop_e, ov_e, addr_m, irq, im, ie,
                output exc_flush, exc_code, exc_epc, exc_bd, in_handler, pend);
endinterface

// File: rtl/exc_track.sv
// exc_track: carries the earliest exception per instruction down F/D/E/M and commits it, or a masked interrupt, at M
module exc_track #(
  parameter int          NIRQ       = 6,
  parameter logic [31:0] PC_LO      = 32'h3000,
  parameter logic [31:0] PC_HI      = 32'h4ffc,
  parameter logic [31:0] DM_TOP     = 32'h2ffc,
  parameter int          NDEV       = 2,
  parameter logic [31:0] DEV_BASE   = 32'h7f00,
  parameter logic [31:0] DEV_STRIDE = 32'h10,
  parameter logic [31:0] DEV_SIZE   = 32'd12
) (
  input logic        clk,
  input logic        reset,
  exc_track_if.slave bus
);
  localparam logic [0:0] NORMAL = 1'b0, HANDLER = 1'b1;
  typedef struct packed {
    logic        v;
    logic        x;
    logic [4:0]  c;
    logic [31:0] pc;
    logic        bd;
    logic        er;
    logic [2:0]  mo;
  } rec_t;
  rec_t r_d, r_e, r_m, w_d, w_e, w_m;
  logic [NIRQ-1:0] r_s1, r_s2;
  logic [0:0]  r_st;
  logic [4:0]  r_code, w_code;
  logic [31:0] r_epc, w_base;
  logic        r_bd;
  logic w_fbad, w_word, w_half, w_st, w_dm, w_dev, w_ro, w_legal, w_mexc, w_int, w_commit, w_eret, w_flush;
  always_comb begin
    w_fbad = (|bus.pc_f[1:0]) | (bus.pc_f < PC_LO) | (bus.pc_f > PC_HI);
    w_d = '0;
    w_d.v = 1'b1;
    w_d.x = w_fbad;
    w_d.c = w_fbad ? 5'd4 : 5'd0;
    w_d.pc = bus.pc_f;
    w_e = r_d;
    w_e.x = r_d.x | bus.ri_d;
    w_e.c = r_d.x ? r_d.c : bus.ri_d ? 5'd10 : 5'd0;
    w_e.bd = bus.bd_d;
    w_e.er = bus.eret_d;
    w_m = r_e;
    w_m.mo = bus.memop_e;
    w_m.x = r_e.x | bus.ov_e;
    w_m.c = r_e.x ? r_e.c : !bus.ov_e ? 5'd0 : bus.memop_e == 3'd0 ? 5'd12 : bus.memop_e >= 3'd4 ? 5'd5 : 5'd4;
    w_word = r_m.mo == 3'd1 || r_m.mo == 3'd4;
    w_half = r_m.mo == 3'd2 || r_m.mo == 3'd5;
    w_st = r_m.mo >= 3'd4;
    w_dm = bus.addr_m <= DM_TOP;
    w_dev = 1'b0;
    w_ro = 1'b0;
    w_base = '0;
    for (int k = 0; k < NDEV; k++) begin
      w_base = DEV_BASE + 32'(k) * DEV_STRIDE;
      if (bus.addr_m >= w_base && bus.addr_m <= w_base + DEV_SIZE - 32'd1) begin
        w_dev = 1'b1;
        w_ro = bus.addr_m - w_base == 32'd8;
      end
    end
    w_legal = (w_word ? bus.addr_m[1:0] == 2'd0 : w_half ? !bus.addr_m[0] : 1'b1) &
              (w_dm | (w_word & w_dev & !(w_st & w_ro)));
    w_mexc = r_m.x | (r_m.mo != 3'd0 & !w_legal);
    // interrupts only land on a real instruction and pre-empt its own exception
    w_int = r_st == NORMAL & bus.ie & (|(r_s2 & bus.im)) & r_m.v;
    w_commit = r_m.v & (w_int | w_mexc);
    w_code = w_int ? 5'd0 : r_m.x ? r_m.c : w_st ? 5'd5 : 5'd4;
    w_eret = r_m.v & r_m.er & !w_mexc & r_st == HANDLER;
    w_flush = w_commit | w_eret;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d <= '0;
      r_e <= '0;
      r_m <= '0;
      r_s1 <= '0;
      r_s2 <= '0;
      r_st <= NORMAL;
      r_code <= '0;
      r_epc <= '0;
      r_bd <= 1'b0;
    end else begin
      r_s1 <= bus.irq;
      r_s2 <= r_s1;
      if (w_flush) begin
        r_d <= '0;
        r_e <= '0;
        r_m <= '0;
      end else begin
        r_m <= bus.stall ? '0 : w_m;
        if (!bus.stall) begin
          r_d <= w_d;
          r_e <= w_e;
        end
      end
      if (w_commit) begin
        r_code <= w_code;
        r_st <= HANDLER;
        if (r_st == NORMAL) begin
          r_epc <= r_m.bd ? r_m.pc - 32'd4 : r_m.pc;
          r_bd <= r_m.bd;
        end
      end else if (w_eret) r_st <= NORMAL;
    end
  end
  assign bus.exc_flush = w_flush;
  assign bus.exc_code = r_code;
  assign bus.exc_epc = r_epc;
  assign bus.exc_bd = r_bd;
  assign bus.in_handler = r_st == HANDLER;
  assign bus.pend = r_s2;
endmodule

// File: tb/tb_exc_track.sv
// tb_exc_track: directed instructions push expected commits; a flush monitor pops and checks them
module tb_exc_track;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exc_track_if #(.NIRQ(6)) bus();
  exc_track dut(.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  typedef struct {
    int          fc;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic        h;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [4:0]  m_code = '0;
  logic [31:0] m_epc = '0;
  logic        m_bd = 1'b0;
  logic        m_h = 1'b0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] r);
    checks++;
    if (a !== r) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, a, r);
    end
  endtask
  always @(negedge clk) begin
    if (reset && bus.exc_flush) begin
      if (q.size() == 0) chk("unexpected_flush", 32'(cyc), 32'hffffffff);
      else begin
        e = q.pop_front();
        chk("flush_cycle", 32'(cyc), 32'(e.fc));
        @(posedge clk);
        #1;
        chk("exc_code", 32'(bus.exc_code), 32'(e.code));
        chk("exc_epc", bus.exc_epc, e.epc);
        chk("exc_bd", 32'(bus.exc_bd), 32'(e.bd));
        chk("in_handler", 32'(bus.in_handler), 32'(e.h));
      end
    end
  end
  // kind: 0 nothing commits, 1 exception commits, 2 eret commits
  task automatic issue(input logic [31:0] pc, input logic ri, input logic bd, input logic er,
                       input logic [2:0] mo, input logic ov, input logic [31:0] ad, input int ns,
                       input logic ie_m, input int kind, input logic [4:0] code);
    exp_t x;
    @(posedge clk);
    #1;
    bus.pc_f = pc;
    if (kind == 1) begin
      m_code = code;
      if (!m_h) begin
        m_epc = bd ? pc - 32'd4 : pc;
        m_bd = bd;
      end
      m_h = 1'b1;
    end else if (kind == 2) m_h = 1'b0;
    if (kind != 0) begin
      x.fc = cyc + 3 + ns;
      x.code = m_code;
      x.epc = m_epc;
      x.bd = m_bd;
      x.h = m_h;
      q.push_back(x);
    end
    @(posedge clk);
    #1;
    bus.pc_f = 32'h3000;
    bus.ri_d = ri;
    bus.bd_d = bd;
    bus.eret_d = er;
    for (int k = 0; k < ns; k++) begin
      bus.stall = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.stall = 1'b0;
    @(posedge clk);
    #1;
    {bus.ri_d, bus.bd_d, bus.eret_d} = '0;
    bus.memop_e = mo;
    bus.ov_e = ov;
    @(posedge clk);
    #1;
    bus.memop_e = '0;
    bus.ov_e = 1'b0;
    bus.addr_m = ad;
    bus.ie = ie_m;
    @(posedge clk);
    #1;
    bus.addr_m = '0;
    bus.ie = 1'b0;
  endtask
  task automatic eret();
    issue(32'h3004, 0, 0, 1, 0, 0, 0, 0, 0, 2, 0);
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_code"}, 32'(bus.exc_code), 0);
    chk({n, "_epc"}, bus.exc_epc, 0);
    chk({n, "_bd"}, 32'(bus.exc_bd), 0);
    chk({n, "_hand"}, 32'(bus.in_handler), 0);
    chk({n, "_flush"}, 32'(bus.exc_flush), 0);
    chk({n, "_pend"}, 32'(bus.pend), 0);
  endtask
  initial begin
    bus.stall = 0; bus.pc_f = 32'h3000; bus.ri_d = 0; bus.bd_d = 0; bus.eret_d = 0;
    bus.memop_e = 0; bus.ov_e = 0; bus.addr_m = 0; bus.irq = 0; bus.im = 0; bus.ie = 0;
    #12;
    chk_zero("reset");
    reset = 1'b1;
    repeat (3) @(posedge clk);
    issue(32'h3004, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    issue(32'h3002, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    eret();
    issue(32'h3000, 0, 0, 0, 1, 0, 32'h7f14, 0, 0, 0, 0);
    issue(32'h3010, 0, 0, 0, 4, 0, 32'h7f18, 0, 0, 1, 5);
    eret();
    issue(32'h3020, 0, 0, 0, 2, 0, 32'h3000, 0, 0, 1, 4);
    eret();
    issue(32'h3030, 1, 0, 0, 0, 1, 0, 0, 0, 1, 10);
    eret();
    issue(32'h3008, 0, 1, 0, 0, 1, 0, 0, 0, 1, 12);
    eret();
    issue(32'h3040, 0, 0, 0, 4, 0, 32'h7f04, 0, 0, 0, 0);
    issue(32'h3040, 0, 0, 0, 1, 0, 32'h7f08, 0, 0, 0, 0);
    issue(32'h3040, 0, 0, 0, 3, 0, 32'h2ffc, 0, 0, 0, 0);
    issue(32'h3044, 0, 0, 0, 6, 0, 32'h7f00, 0, 0, 1, 5);
    eret();
    issue(32'h3048, 0, 0, 0, 5, 0, 32'h0103, 0, 0, 1, 5);
    eret();
    issue(32'h304c, 0, 0, 0, 1, 1, 32'h0100, 0, 0, 1, 4);
    eret();
    issue(32'h3050, 0, 0, 0, 4, 1, 32'h0100, 0, 0, 1, 5);
    eret();
    issue(32'h3054, 0, 0, 0, 1, 0, 32'h7f20, 0, 0, 1, 4);
    eret();
    issue(32'h3006, 0, 0, 0, 0, 0, 0, 2, 0, 1, 4);
    eret();
    issue(32'h5000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    eret();
    issue(32'h4ffc, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.irq = 6'b000100;
    bus.im = 6'b000100;
    repeat (3) @(posedge clk);
    #1;
    chk("pend", 32'(bus.pend), 32'h4);
    issue(32'h3060, 0, 0, 0, 4, 0, 32'h7f18, 0, 1, 1, 0);
    eret();
    issue(32'h3064, 0, 0, 0, 4, 0, 32'h7f18, 0, 0, 1, 5);
    issue(32'h3001, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk_zero("async_reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_hand", 32'(bus.in_handler), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
